// File: rtl/tsmf_split_mc.sv
`default_nettype none
// ============================================================================
// Module   : tsmf_split_mc
// Purpose  : Routes TSMF packets by relative stream ID into per-channel ring
//            buffers (128-bit lines) in an external RAM, with credit return.
//            Optional continuity-counter check: define TSMF_CC_CHK_EN.
// Revision : 1.0  initial release
// ============================================================================
module tsmf_split_mc #(
    parameter  int CH_NUM   = 8,
    parameter  int SLOT_NUM = 64,
    localparam int CH_W     = $clog2(CH_NUM),
    localparam int SLOT_W   = $clog2(SLOT_NUM),
    localparam int ADDR_W   = CH_W + SLOT_W + 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       ts_din,
    input  logic              ts_din_en,
    input  logic [7:0]        freq_con_din,
    input  logic              freq_con_din_en,
    input  logic [7:0]        channel_din,
    input  logic              channel_din_en,
    output logic              ts_ram_wr,
    output logic [ADDR_W-1:0] ts_ram_waddr,
    output logic [127:0]      ts_ram_wdata,
    output logic              ts_ram_valid,
    output logic [CH_W-1:0]   ts_ram_vch,
    output logic [SLOT_W-1:0] ts_ram_vslot,
    input  logic              ts_ram_rel,
    input  logic [CH_W-1:0]   ts_ram_rel_ch,
`ifdef TSMF_CC_CHK_EN
    output logic              cc_err,
`endif
    output logic              drop_pulse,
    output logic              ovf_pulse
);

    localparam logic [SLOT_W:0] c_occ_full = (SLOT_W+1)'(SLOT_NUM);
    localparam logic [5:0]      c_last_idx = 6'd46;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_HDR  = 3'd1,
        S_PAY  = 3'd2,
        S_DONE = 3'd3,
        S_SKIP = 3'd4
    } state_t;

    state_t r_state, w_state_nxt;

    logic [CH_W:0]     r_shadow [16];
    logic [CH_W:0]     r_map    [16];
    logic [4:0]        r_cfg_idx;
    logic              r_cfg_en_q;
    logic              r_commit_pend;
    logic [SLOT_W-1:0] r_wptr [CH_NUM];
    logic [SLOT_W:0]   r_occ  [CH_NUM];
    logic              r_en_q;
    logic [3:0]        r_sid;
    logic [CH_W-1:0]   r_ch;
    logic [SLOT_W-1:0] r_slot;
    logic [5:0]        r_widx;
    logic [95:0]       r_acc;

    logic              w_start, w_accept, w_drop, w_ovf, w_wr, w_commit, w_cfg_fall;
    logic              w_flush_hit;
    logic [CH_W:0]     w_map_ent;
    logic [CH_W-1:0]   w_map_ch;
    logic [CH_W-1:0]   w_flush_ch;
    logic [CH_NUM-1:0] w_inc, w_dec, w_flush;

    // A packet starts only on a rising enable, so a packet cut by reset is skipped.
    assign w_start     = ts_din_en && !r_en_q;
    assign w_map_ent   = r_map[r_sid];
    assign w_map_ch    = w_map_ent[CH_W-1:0];
    assign w_flush_ch  = channel_din[CH_W-1:0];
    assign w_flush_hit = channel_din_en && (w_flush_ch == r_ch);
    assign w_cfg_fall  = r_cfg_en_q && !freq_con_din_en;
    assign w_commit    = (w_cfg_fall || r_commit_pend) && (r_state == S_IDLE);

    always_ff @(posedge clk) begin
        r_en_q <= ts_din_en;
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_drop      = 1'b0;
        w_ovf       = 1'b0;
        w_wr        = 1'b0;
        case (r_state)
            S_IDLE: if (w_start) w_state_nxt = S_HDR;
            S_HDR: begin
                if (!ts_din_en) begin
                    w_drop      = 1'b1;
                    w_state_nxt = S_IDLE;
                end else if (ts_din[31:24] != 8'h47 || !w_map_ent[CH_W]) begin
                    w_drop      = 1'b1;
                    w_state_nxt = S_SKIP;
                end else if (r_occ[w_map_ch] == c_occ_full) begin
                    w_ovf       = 1'b1;
                    w_state_nxt = S_SKIP;
                end else begin
                    w_accept    = 1'b1;
                    w_state_nxt = S_PAY;
                end
            end
            S_PAY: begin
                if (!ts_din_en) begin
                    w_drop      = 1'b1;
                    w_state_nxt = S_IDLE;
                end else if (w_flush_hit) begin
                    w_drop      = 1'b1;
                    w_state_nxt = S_SKIP;
                end else begin
                    w_wr = (r_widx[1:0] == 2'd3) || (r_widx == c_last_idx);
                    if (r_widx == c_last_idx) w_state_nxt = S_DONE;
                end
            end
            S_DONE: w_state_nxt = ts_din_en ? S_SKIP : S_IDLE;
            S_SKIP: if (!ts_din_en) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ts_ram_wr    <= 1'b0;
            ts_ram_waddr <= '0;
            ts_ram_wdata <= '0;
            ts_ram_valid <= 1'b0;
            ts_ram_vch   <= '0;
            ts_ram_vslot <= '0;
            drop_pulse   <= 1'b0;
            ovf_pulse    <= 1'b0;
            r_sid        <= '0;
            r_ch         <= '0;
            r_slot       <= '0;
            r_widx       <= '0;
            r_acc        <= '0;
        end else begin
            ts_ram_wr    <= w_wr;
            drop_pulse   <= w_drop;
            ovf_pulse    <= w_ovf;
            ts_ram_valid <= (r_state == S_DONE);
            if (r_state == S_DONE) begin
                ts_ram_vch   <= r_ch;
                ts_ram_vslot <= r_slot;
            end
            if (r_state == S_IDLE && w_start) r_sid <= ts_din[3:0];
            if (w_accept) begin
                r_ch   <= w_map_ch;
                r_slot <= r_wptr[w_map_ch];
                r_widx <= 6'd1;
                r_acc  <= {r_acc[63:0], ts_din};
            end
            if (r_state == S_PAY && ts_din_en) begin
                r_widx <= r_widx + 6'd1;
                r_acc  <= {r_acc[63:0], ts_din};
            end
            if (w_wr) begin
                ts_ram_waddr <= {r_ch, r_slot, r_widx[5:2]};
                // The last line carries only three words; the low word is zero.
                ts_ram_wdata <= (r_widx == c_last_idx) ? {r_acc[63:0], ts_din, 32'h0}
                                                       : {r_acc, ts_din};
            end
        end
    end

    always_comb begin
        w_inc   = '0;
        w_dec   = '0;
        w_flush = '0;
        for (int c = 0; c < CH_NUM; c++) begin
            w_inc[c]   = (r_state == S_DONE) && (r_ch == CH_W'(c));
            w_dec[c]   = ts_ram_rel && (ts_ram_rel_ch == CH_W'(c)) && (r_occ[c] != '0);
            w_flush[c] = channel_din_en && (w_flush_ch == CH_W'(c));
        end
    end

    always_ff @(posedge clk) begin
        for (int c = 0; c < CH_NUM; c++) begin
            if (rst || w_flush[c]) begin
                r_wptr[c] <= '0;
                r_occ[c]  <= '0;
            end else begin
                if (w_inc[c]) r_wptr[c] <= r_wptr[c] + 1'b1;
                if (w_inc[c] && !w_dec[c])      r_occ[c] <= r_occ[c] + 1'b1;
                else if (!w_inc[c] && w_dec[c]) r_occ[c] <= r_occ[c] - 1'b1;
            end
        end
    end

    // Shadow table fills during a burst; the active map only changes between packets.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) begin
                r_shadow[i] <= '0;
                r_map[i]    <= '0;
            end
            r_cfg_idx     <= '0;
            r_cfg_en_q    <= 1'b0;
            r_commit_pend <= 1'b0;
        end else begin
            r_cfg_en_q <= freq_con_din_en;
            if (!freq_con_din_en) begin
                r_cfg_idx <= '0;
            end else if (!r_cfg_idx[4]) begin
                r_shadow[r_cfg_idx[3:0]] <= {freq_con_din[7], freq_con_din[CH_W-1:0]};
                r_cfg_idx                <= r_cfg_idx + 5'd1;
            end
            if (w_commit) begin
                for (int i = 0; i < 16; i++) r_map[i] <= r_shadow[i];
                r_commit_pend <= 1'b0;
            end else if (w_cfg_fall) begin
                r_commit_pend <= 1'b1;
            end
        end
    end

`ifdef TSMF_CC_CHK_EN
    logic [3:0]  r_cc_last [16];
    logic [15:0] r_cc_seen;
    logic [3:0]  r_cc_cur;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) r_cc_last[i] <= '0;
            r_cc_seen <= '0;
            r_cc_cur  <= '0;
            cc_err    <= 1'b0;
        end else begin
            cc_err <= 1'b0;
            if (r_state == S_PAY && ts_din_en && r_widx == 6'd1) r_cc_cur <= ts_din[27:24];
            if (w_commit) r_cc_seen <= '0;
            if (r_state == S_DONE) begin
                cc_err               <= r_cc_seen[r_sid] && (r_cc_cur != r_cc_last[r_sid] + 4'd1);
                r_cc_last[r_sid]     <= r_cc_cur;
                r_cc_seen[r_sid]     <= 1'b1;
            end
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_tsmf_split_mc.sv
`default_nettype none
// ============================================================================
// Module   : tb_tsmf_split_mc
// Purpose  : Scoreboard bench for tsmf_split_mc: routing, slot fill/overflow,
//            drops, short packets, live reconfig, flush and mid-packet reset.
// Revision : 1.0  initial release
// ============================================================================
module tb_tsmf_split_mc;

    localparam int CH_NUM   = 8;
    localparam int SLOT_NUM = 64;
    localparam int CH_W     = 3;
    localparam int SLOT_W   = 6;
    localparam int ADDR_W   = 13;

    logic              clk = 1'b0;
    logic              rst;
    logic [31:0]       ts_din;
    logic              ts_din_en;
    logic [7:0]        freq_con_din;
    logic              freq_con_din_en;
    logic [7:0]        channel_din;
    logic              channel_din_en;
    logic              ts_ram_wr;
    logic [ADDR_W-1:0] ts_ram_waddr;
    logic [127:0]      ts_ram_wdata;
    logic              ts_ram_valid;
    logic [CH_W-1:0]   ts_ram_vch;
    logic [SLOT_W-1:0] ts_ram_vslot;
    logic              ts_ram_rel;
    logic [CH_W-1:0]   ts_ram_rel_ch;
    logic              drop_pulse;
    logic              ovf_pulse;
`ifdef TSMF_CC_CHK_EN
    logic              cc_err;
`endif

    tsmf_split_mc #(.CH_NUM(CH_NUM), .SLOT_NUM(SLOT_NUM)) dut (
        .clk(clk), .rst(rst),
        .ts_din(ts_din), .ts_din_en(ts_din_en),
        .freq_con_din(freq_con_din), .freq_con_din_en(freq_con_din_en),
        .channel_din(channel_din), .channel_din_en(channel_din_en),
        .ts_ram_wr(ts_ram_wr), .ts_ram_waddr(ts_ram_waddr), .ts_ram_wdata(ts_ram_wdata),
        .ts_ram_valid(ts_ram_valid), .ts_ram_vch(ts_ram_vch), .ts_ram_vslot(ts_ram_vslot),
        .ts_ram_rel(ts_ram_rel), .ts_ram_rel_ch(ts_ram_rel_ch),
`ifdef TSMF_CC_CHK_EN
        .cc_err(cc_err),
`endif
        .drop_pulse(drop_pulse), .ovf_pulse(ovf_pulse)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [127:0]      data;
    } wr_t;

    wr_t                      wr_q [$];
    logic [CH_W+SLOT_W-1:0]   val_q[$];
    logic [1:0]               ev_q [$];   // 2'b01 drop, 2'b10 overflow

    logic [7:0] map_m    [16];
    logic [7:0] shadow_m [16];
    logic [7:0] cfg_bytes[18];
    int         occ_m [CH_NUM];
    int         wptr_m[CH_NUM];
    int         checks = 0;
    int         errors = 0;
    int         tag    = 0;

    wr_t                    mon_w;
    logic [CH_W+SLOT_W-1:0] mon_v;
    logic [1:0]             mon_e;

    task automatic chk(input string name, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", name, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (ts_ram_wr) begin
            if (wr_q.size() == 0) chk("ram_wr_unexpected", ts_ram_wr, 1'b0);
            else begin
                mon_w = wr_q.pop_front();
                chk("ram_waddr", ts_ram_waddr, mon_w.addr);
                chk("ram_wdata", ts_ram_wdata, mon_w.data);
            end
        end
        if (ts_ram_valid) begin
            if (val_q.size() == 0) chk("ram_valid_unexpected", ts_ram_valid, 1'b0);
            else begin
                mon_v = val_q.pop_front();
                chk("ram_valid_ch_slot", {ts_ram_vch, ts_ram_vslot}, mon_v);
            end
        end
        if (drop_pulse || ovf_pulse) begin
            mon_e = (ev_q.size() == 0) ? 2'b00 : ev_q.pop_front();
            chk("drop_ovf_event", {ovf_pulse, drop_pulse}, mon_e);
        end
    end

    function automatic void model_reset();
        for (int i = 0; i < 16; i++) begin
            map_m[i]    = 8'h00;
            shadow_m[i] = 8'h00;
        end
        for (int c = 0; c < CH_NUM; c++) begin
            occ_m[c]  = 0;
            wptr_m[c] = 0;
        end
    endfunction

    function automatic void commit_model();
        for (int i = 0; i < 16; i++) map_m[i] = shadow_m[i];
    endfunction

    task automatic cfg_burst(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            freq_con_din_en = 1'b1;
            freq_con_din    = cfg_bytes[i];
            if (i < 16) shadow_m[i] = cfg_bytes[i];
        end
        @(posedge clk); #1;
        freq_con_din_en = 1'b0;
        freq_con_din    = 8'h00;
    endtask

    task automatic release_slot(input int ch);
        @(posedge clk); #1;
        ts_ram_rel    = 1'b1;
        ts_ram_rel_ch = CH_W'(ch);
        if (occ_m[ch] > 0) occ_m[ch]--;
        @(posedge clk); #1;
        ts_ram_rel = 1'b0;
    endtask

    // Predicts the packet outcome from the model, then drives header + npay words.
    task automatic send_pkt(input logic [3:0] sid, input logic [7:0] sync, input int npay,
                            input int flush_at, input int rst_at);
        logic [7:0]  e;
        logic [31:0] pw[47];
        wr_t         w;
        int          ch, lim, li;
        e  = map_m[sid];
        ch = int'(e[CH_W-1:0]);
        pw[0] = {sync, 24'h100100};
        for (int k = 1; k < 47; k++) pw[k] = (tag << 16) | k;
        tag++;
        lim = npay;
        if (flush_at >= 0 && flush_at < lim) lim = flush_at;
        if (rst_at >= 0 && rst_at < lim) lim = rst_at;
        if (sync != 8'h47 || !e[7]) ev_q.push_back(2'b01);
        else if (occ_m[ch] == SLOT_NUM) ev_q.push_back(2'b10);
        else begin
            for (int l = 0; l < 12; l++) begin
                li = (l == 11) ? 46 : 4 * l + 3;
                if (li < lim) begin
                    w.addr = {CH_W'(ch), SLOT_W'(wptr_m[ch]), 4'(l)};
                    w.data = (l == 11) ? {pw[44], pw[45], pw[46], 32'h0}
                                       : {pw[4*l], pw[4*l+1], pw[4*l+2], pw[4*l+3]};
                    wr_q.push_back(w);
                end
            end
            if (lim >= 47) begin
                val_q.push_back({CH_W'(ch), SLOT_W'(wptr_m[ch])});
                wptr_m[ch] = (wptr_m[ch] + 1) % SLOT_NUM;
                occ_m[ch]++;
            end else if (rst_at < 0) begin
                ev_q.push_back(2'b01);
            end
            if (flush_at >= 0) begin
                occ_m[ch]  = 0;
                wptr_m[ch] = 0;
            end
        end
        @(posedge clk); #1;
        ts_din_en = 1'b1;
        ts_din    = {28'h0, sid};
        for (int k = 0; k < npay; k++) begin
            @(posedge clk); #1;
            ts_din         = pw[k];
            channel_din_en = (k == flush_at);
            channel_din    = 8'(ch);
            rst            = (k == rst_at);
        end
        @(posedge clk); #1;
        ts_din_en      = 1'b0;
        ts_din         = 32'h0;
        channel_din_en = 1'b0;
        rst            = 1'b0;
        if (rst_at >= 0) model_reset();
        repeat (3) @(posedge clk);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; ts_din = '0; ts_din_en = 1'b0; freq_con_din = '0; freq_con_din_en = 1'b0;
        channel_din = '0; channel_din_en = 1'b0; ts_ram_rel = 1'b0; ts_ram_rel_ch = '0;
        model_reset();
        repeat (3) @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("reset_wr",    ts_ram_wr,    1'b0);
        chk("reset_waddr", ts_ram_waddr, '0);
        chk("reset_wdata", ts_ram_wdata, '0);
        chk("reset_valid", {ts_ram_valid, ts_ram_vch, ts_ram_vslot}, '0);
        chk("reset_pulses", {drop_pulse, ovf_pulse}, 2'b00);

        // Stream 0 -> ch 2, stream 1 -> ch 3; bytes past 16 must be ignored.
        for (int i = 0; i < 18; i++) cfg_bytes[i] = 8'h00;
        cfg_bytes[0] = 8'h82; cfg_bytes[1] = 8'h83; cfg_bytes[16] = 8'h85; cfg_bytes[17] = 8'h86;
        cfg_burst(18);
        commit_model();
        repeat (2) @(posedge clk);

        send_pkt(4'd0, 8'h47, 47, -1, -1);
        send_pkt(4'd1, 8'h47, 47, -1, -1);
        send_pkt(4'd5, 8'h47, 47, -1, -1);
        send_pkt(4'd0, 8'h00, 47, -1, -1);
        send_pkt(4'd0, 8'h47, 20, -1, -1);
        send_pkt(4'd0, 8'h47, 47, -1, -1);

        while (occ_m[2] < SLOT_NUM) send_pkt(4'd0, 8'h47, 47, -1, -1);
        send_pkt(4'd0, 8'h47, 47, -1, -1);
        release_slot(2);
        send_pkt(4'd0, 8'h47, 47, -1, -1);

        // Remap stream 1 -> ch 4 while a stream-1 packet is in flight.
        cfg_bytes[0] = 8'h82; cfg_bytes[1] = 8'h84;
        fork
            send_pkt(4'd1, 8'h47, 47, -1, -1);
            begin
                repeat (15) @(posedge clk);
                cfg_burst(2);
            end
        join
        commit_model();
        send_pkt(4'd1, 8'h47, 47, -1, -1);

        release_slot(2);
        release_slot(2);
        send_pkt(4'd0, 8'h47, 47, 10, -1);
        send_pkt(4'd0, 8'h47, 47, -1, -1);

        send_pkt(4'd1, 8'h47, 47, -1, 9);
        send_pkt(4'd0, 8'h47, 47, -1, -1);
        cfg_burst(2);
        commit_model();
        repeat (2) @(posedge clk);
        send_pkt(4'd0, 8'h47, 47, -1, -1);
        send_pkt(4'd1, 8'h47, 47, -1, -1);

        repeat (10) @(posedge clk);
        chk("pending_writes", wr_q.size(),  0);
        chk("pending_valids", val_q.size(), 0);
        chk("pending_events", ev_q.size(),  0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
